delayed_write_scheduler: RTL and testbench

- Schedules delayed writes into a single WIDTH-bit value register, modelling multiple outstanding nonblocking writes of the form "reg <= #d data" in clocked hardware.
- Requesters issue (delay, data) pairs. Each pair is held in one of DEPTH slots, counted down, and committed to the register when it expires.
- Sits between stimulus generators and the register under test. It is the sequencer and collision resolver for that register.

---
 rtl/delayed_write_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_delayed_write_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/delayed_write_scheduler.sv
// ----------------------------------------------------------------------------
// delayed_write_scheduler
//
// Purpose:
//   Holds up to DEPTH outstanding delayed writes ("reg <= #d data") aimed at a
//   single WIDTH-bit value register. Each accepted (delay, data) pair sits in
//   a slot and counts down. It commits to the value register when its count
//   expires. If several slots expire on the same edge, the most recently
//   accepted one (smallest age) wins, giving last-writer-wins ordering.
//
// Handshake:
//   A request transfers on a rising edge where req_valid && req_ready && !flush.
//   req_ready depends only on the occupancy before the edge. A slot freed by
//   retirement on an edge is offered from the next cycle.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   req_valid    in   write request present
//   req_ready    out  a free slot exists
//   req_delay    in   [DLY_W]  cycles to wait after acceptance
//   req_data     in   [WIDTH]  data to commit
//   flush        in   synchronous discard of all pending writes
//   value        out  [WIDTH]  committed register value
//   value_valid  out  set by the first commit after reset, then sticky
//   pending      out  [$clog2(DEPTH+1)] occupied slots after the last edge
//   busy         out  pending != 0
//
// Optional feature (macro DWS_STATS_EN):
//   commit_count    out [16] wrapping count of edges that committed a value
//   supersede_count out [16] wrapping count of retiring writes that lost
//                            a same-edge collision
// ----------------------------------------------------------------------------
module delayed_write_scheduler #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int DLY_W = 4,
    localparam int PW = $clog2(DEPTH + 1),
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [DLY_W-1:0] req_delay,
    input  logic [WIDTH-1:0] req_data,
    input  logic             flush,
    output logic [WIDTH-1:0] value,
    output logic             value_valid,
    output logic [PW-1:0]    pending,
`ifdef DWS_STATS_EN
    output logic [15:0]      commit_count,
    output logic [15:0]      supersede_count,
`endif
    output logic             busy
);

    // Slot storage
    logic [DEPTH-1:0] r_occ;
    logic [DLY_W-1:0] r_cnt  [DEPTH];
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DLY_W:0]   r_age  [DEPTH];

    logic [WIDTH-1:0] r_value;
    logic             r_value_valid;
    logic [PW-1:0]    r_pending;
    logic             r_busy;

    logic             w_free_any;
    logic [IW-1:0]    w_free_idx;
    logic [DEPTH-1:0] w_ret;
    logic             w_win_any;
    logic [WIDTH-1:0] w_win_data;
    logic [DLY_W:0]   w_win_age;
    logic [PW-1:0]    w_ret_num;
    logic             w_accept;
    logic [DEPTH-1:0] w_occ_next;
    logic [PW-1:0]    w_pend_next;

    // Lowest-index free slot: scan downwards so the last hit is the lowest.
    always_comb begin
        w_free_any = 1'b0;
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_occ[i]) begin
                w_free_any = 1'b1;
                w_free_idx = IW'(i);
            end
        end
    end

    // Retirement and collision resolution. Ages are unique (one accept per
    // edge), so a strict less-than selects a single winner.
    always_comb begin
        w_ret      = '0;
        w_win_any  = 1'b0;
        w_win_data = '0;
        w_win_age  = '0;
        w_ret_num  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_ret[i] = r_occ[i] && (r_cnt[i] == '0);
            if (w_ret[i]) begin
                w_ret_num = w_ret_num + PW'(1);
                if (!w_win_any || (r_age[i] < w_win_age)) begin
                    w_win_any  = 1'b1;
                    w_win_data = r_data[i];
                    w_win_age  = r_age[i];
                end
            end
        end
    end

    // flush blocks acceptance even though req_ready may read 1.
    assign w_accept = req_valid && w_free_any && !flush;

    always_comb begin
        w_occ_next  = '0;
        w_pend_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ_next[i] = r_occ[i] && !w_ret[i] && !flush;
            if (w_accept && (w_free_idx == IW'(i))) begin
                w_occ_next[i] = 1'b1;
            end
            if (w_occ_next[i]) begin
                w_pend_next = w_pend_next + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_cnt[i]  <= '0;
                r_data[i] <= '0;
                r_age[i]  <= '0;
            end
        end else begin
            r_occ <= w_occ_next;
            for (int i = 0; i < DEPTH; i++) begin
                if (w_accept && (w_free_idx == IW'(i))) begin
                    r_cnt[i]  <= req_delay;
                    r_data[i] <= req_data;
                    r_age[i]  <= '0;
                end else if (r_occ[i] && !w_ret[i] && !flush) begin
                    r_cnt[i] <= r_cnt[i] - DLY_W'(1);
                    if (r_age[i] != '1) begin
                        r_age[i] <= r_age[i] + (DLY_W+1)'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value       <= '0;
            r_value_valid <= 1'b0;
            r_pending     <= '0;
            r_busy        <= 1'b0;
        end else begin
            if (w_win_any && !flush) begin
                r_value       <= w_win_data;
                r_value_valid <= 1'b1;
            end
            r_pending <= w_pend_next;
            r_busy    <= (w_occ_next != '0);
        end
    end

`ifdef DWS_STATS_EN
    logic [15:0] r_commit_count;
    logic [15:0] r_supersede_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_commit_count    <= '0;
            r_supersede_count <= '0;
        end else if (w_win_any && !flush) begin
            r_commit_count    <= r_commit_count + 16'd1;
            // every retiring slot except the winner was superseded
            r_supersede_count <= r_supersede_count + 16'(w_ret_num) - 16'd1;
        end
    end

    assign commit_count    = r_commit_count;
    assign supersede_count = r_supersede_count;
`endif

    assign req_ready   = w_free_any;
    assign value       = r_value;
    assign value_valid = r_value_valid;
    assign pending     = r_pending;
    assign busy        = r_busy;

endmodule

// File: tb/tb_delayed_write_scheduler.sv
// ----------------------------------------------------------------------------
// tb_delayed_write_scheduler
//   Directed bench for delayed_write_scheduler (WIDTH=4, DEPTH=4, DLY_W=4).
//   A vector table covers single writes, collisions and flush; hand-written
//   sequences cover the full/stall case and reset in mid-count.
// ----------------------------------------------------------------------------
module tb_delayed_write_scheduler;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int DLY_W = 4;
    localparam int PW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [DLY_W-1:0] req_delay;
    logic [WIDTH-1:0] req_data;
    logic             flush;
    logic [WIDTH-1:0] value;
    logic             value_valid;
    logic [PW-1:0]    pending;
    logic             busy;
`ifdef DWS_STATS_EN
    logic [15:0]      commit_count;
    logic [15:0]      supersede_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    delayed_write_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DLY_W(DLY_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_delay       (req_delay),
        .req_data        (req_data),
        .flush           (flush),
        .value           (value),
        .value_valid     (value_valid),
        .pending         (pending),
`ifdef DWS_STATS_EN
        .commit_count    (commit_count),
        .supersede_count (supersede_count),
`endif
        .busy            (busy)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             valid;
        logic [DLY_W-1:0] dly;
        logic [WIDTH-1:0] data;
        logic             flush;
        logic [WIDTH-1:0] exp_value;
        logic             exp_vvalid;
        int               exp_pending;
        logic             exp_ready;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input int d, input int dat, input logic f,
                       input int ev, input logic evv, input int ep, input logic er);
        vec_t t;
        t.valid       = v;
        t.dly         = DLY_W'(d);
        t.data        = WIDTH'(dat);
        t.flush       = f;
        t.exp_value   = WIDTH'(ev);
        t.exp_vvalid  = evv;
        t.exp_pending = ep;
        t.exp_ready   = er;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // drive inputs, take one edge, sample 1 time unit later
    task automatic step(input logic v, input int d, input int dat, input logic f);
        req_valid = v;
        req_delay = DLY_W'(d);
        req_data  = WIDTH'(dat);
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input int ev, input logic evv,
                               input int ep, input logic er);
        check({tag, ".value"},       int'(value),       ev);
        check({tag, ".value_valid"}, int'(value_valid), int'(evv));
        check({tag, ".pending"},     int'(pending),     ep);
        check({tag, ".busy"},        int'(busy),        (ep != 0) ? 1 : 0);
        check({tag, ".req_ready"},   int'(req_ready),   int'(er));
    endtask

    initial begin
        // ---------------- vector table ----------------
        // idle after reset
        add(0, 0, 0, 0, 0, 0, 0, 1);
        // single write d=9 data 5: commits 10 edges after acceptance
        add(1, 9, 5, 0, 0, 0, 1, 1);
        for (int k = 1; k <= 9; k++) add(0, 0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 5, 1, 0, 1);
        // collision: (3,A) then (2,3), both retire at E0+4, younger wins
        add(1, 3, 'hA, 0, 5, 1, 1, 1);
        add(1, 2, 'h3, 0, 5, 1, 2, 1);
        add(0, 0, 0, 0, 5, 1, 2, 1);
        add(0, 0, 0, 0, 5, 1, 2, 1);
        add(0, 0, 0, 0, 3, 1, 0, 1);
        // d=0 write sets value to 2 one edge after acceptance
        add(1, 0, 2, 0, 3, 1, 1, 1);
        add(0, 0, 0, 0, 2, 1, 0, 1);
        // (5,7) then flush at E0+2, with a request offered on the flush edge
        add(1, 5, 7, 0, 2, 1, 1, 1);
        add(0, 0, 0, 0, 2, 1, 1, 1);
        add(1, 0, 9, 1, 2, 1, 0, 1);
        for (int k = 3; k <= 7; k++) add(0, 0, 0, 0, 2, 1, 0, 1);

        // ---------------- reset ----------------
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_delay = '0;
        req_data  = '0;
        flush     = 1'b0;
        #1;
        check_state("reset", 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].valid, int'(vecs[i].dly), int'(vecs[i].data), vecs[i].flush);
            check_state($sformatf("vec%0d", i), int'(vecs[i].exp_value),
                        vecs[i].exp_vvalid, vecs[i].exp_pending, vecs[i].exp_ready);
        end
`ifdef DWS_STATS_EN
        check("stats.commit_after_table",    int'(commit_count),    3);
        check("stats.supersede_after_table", int'(supersede_count), 1);
`endif

        // ---------------- full / stall ----------------
        // slots 0..3 get d=15 with data 1..4 on edges F0..F3
        for (int k = 0; k < 4; k++) begin
            step(1, 15, k + 1, 0);
            check_state($sformatf("fill%0d", k), 2, 1, k + 1, (k < 3) ? 1'b1 : 1'b0);
        end
        // fifth request (d=0, 8) held while full
        for (int k = 4; k <= 15; k++) begin
            step(1, 0, 8, 0);
            check_state($sformatf("stall%0d", k), 2, 1, 4, 0);
        end
        step(1, 0, 8, 0);               // F0+16: slot 0 retires
        check_state("full.ret0", 1, 1, 3, 1);
        step(1, 0, 8, 0);               // F0+17: fifth accepted, slot 1 retires
        check_state("full.acc5", 2, 1, 3, 1);
        step(0, 0, 0, 0);               // F0+18: slot 2 and fifth collide
        check_state("full.coll", 8, 1, 1, 1);
        step(0, 0, 0, 0);               // F0+19: slot 3 retires
        check_state("full.last", 4, 1, 0, 1);
`ifdef DWS_STATS_EN
        check("stats.commit_after_full",    int'(commit_count),    7);
        check("stats.supersede_after_full", int'(supersede_count), 2);
`endif

        // ---------------- reset in mid-count ----------------
        step(1, 8, 'hF, 0);
        check_state("rst.acc", 4, 1, 1, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check_state("rst.mid", 4, 1, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_state("rst.async", 0, 0, 0, 1);
`ifdef DWS_STATS_EN
        check("stats.commit_reset",    int'(commit_count),    0);
        check("stats.supersede_reset", int'(supersede_count), 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 0, 0);
            check_state($sformatf("rst.after%0d", k), 0, 0, 0, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // global time limit
    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1);
    end

endmodule
